// File: rtl/arm_shifter_pipe.sv
// Two-stage ARM data-processing shifter operand unit with valid/ready on both sides.
// S1 registers the operand and a decoded shift class/amount; S2 registers the shifted result.
module arm_shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH),
  parameter int AMT_W = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rm,
  input  logic [1:0]       shift_type,
  input  logic             reg_mode,
  input  logic [SH_W-1:0]  shift_imm,
  input  logic [AMT_W-1:0] rs_amt,
  input  logic             carry_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry_out,
  output logic [TAG_W-1:0] tag_out
);

  // Every shift reduces to one of these; the shifting classes carry an amount in 1..WIDTH-1.
  typedef enum logic [3:0] {
    CL_PASS,
    CL_LSL,
    CL_LSR,
    CL_ASR,
    CL_ROR,
    CL_RRX,
    CL_ZLSB,
    CL_ZMSB,
    CL_ZERO,
    CL_SIGN,
    CL_RORW
  } cls_t;

  localparam logic [SH_W-1:0] AMT_ONE = SH_W'(1);
  localparam logic [SH_W:0]   W_EXT   = (SH_W + 1)'(WIDTH);

  logic             w_s2_adv;
  logic             w_s1_adv;

  cls_t             w_cls;
  logic [SH_W-1:0]  w_amt;
  logic [31:0]      w_n;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_rm;
  logic             r_cin;
  logic [TAG_W-1:0] r_tag;
  cls_t             r_cls;
  logic [SH_W-1:0]  r_amt;

  logic [SH_W:0]    w_lidx;
  logic [SH_W-1:0]  w_ridx;
  logic [WIDTH-1:0] w_y;
  logic             w_c;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_c;
  logic [TAG_W-1:0] r_tag_out;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_n      = 32'(rs_amt);

  always_comb begin
    w_cls = CL_PASS;
    w_amt = '0;
    if (!reg_mode) begin
      if (shift_imm == '0) begin
        unique case (shift_type)
          2'b00:   w_cls = CL_PASS;
          2'b01:   w_cls = CL_ZMSB;
          2'b10:   w_cls = CL_SIGN;
          default: w_cls = CL_RRX;
        endcase
      end else begin
        w_amt = shift_imm;
        unique case (shift_type)
          2'b00:   w_cls = CL_LSL;
          2'b01:   w_cls = CL_LSR;
          2'b10:   w_cls = CL_ASR;
          default: w_cls = CL_ROR;
        endcase
      end
    end else if (w_n != 32'd0) begin
      unique case (shift_type)
        2'b00: begin
          if (w_n < 32'(WIDTH)) begin
            w_cls = CL_LSL;
            w_amt = w_n[SH_W-1:0];
          end else if (w_n == 32'(WIDTH)) begin
            w_cls = CL_ZLSB;
          end else begin
            w_cls = CL_ZERO;
          end
        end
        2'b01: begin
          if (w_n < 32'(WIDTH)) begin
            w_cls = CL_LSR;
            w_amt = w_n[SH_W-1:0];
          end else if (w_n == 32'(WIDTH)) begin
            w_cls = CL_ZMSB;
          end else begin
            w_cls = CL_ZERO;
          end
        end
        2'b10: begin
          if (w_n < 32'(WIDTH)) begin
            w_cls = CL_ASR;
            w_amt = w_n[SH_W-1:0];
          end else begin
            w_cls = CL_SIGN;
          end
        end
        default: begin
          w_amt = w_n[SH_W-1:0];
          w_cls = (w_amt == '0) ? CL_RORW : CL_ROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_rm       <= '0;
      r_cin      <= 1'b0;
      r_tag      <= '0;
      r_cls      <= CL_PASS;
      r_amt      <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_rm  <= rm;
        r_cin <= carry_in;
        r_tag <= tag_in;
        r_cls <= w_cls;
        r_amt <= w_amt;
      end
    end
  end

  // Amount is 1..WIDTH-1 for every class that indexes with it, so both indices stay in range.
  assign w_lidx = W_EXT - {1'b0, r_amt};
  assign w_ridx = r_amt - AMT_ONE;

  always_comb begin
    w_y = '0;
    w_c = 1'b0;
    unique case (r_cls)
      CL_PASS: begin
        w_y = r_rm;
        w_c = r_cin;
      end
      CL_LSL: begin
        w_y = r_rm << r_amt;
        w_c = r_rm[w_lidx[SH_W-1:0]];
      end
      CL_LSR: begin
        w_y = r_rm >> r_amt;
        w_c = r_rm[w_ridx];
      end
      CL_ASR: begin
        w_y = $signed(r_rm) >>> r_amt;
        w_c = r_rm[w_ridx];
      end
      CL_ROR: begin
        w_y = (r_rm >> r_amt) | (r_rm << w_lidx);
        w_c = r_rm[w_ridx];
      end
      CL_RRX: begin
        w_y = {r_cin, r_rm[WIDTH-1:1]};
        w_c = r_rm[0];
      end
      CL_ZLSB: w_c = r_rm[0];
      CL_ZMSB: w_c = r_rm[WIDTH-1];
      CL_ZERO: w_c = 1'b0;
      CL_SIGN: begin
        w_y = {WIDTH{r_rm[WIDTH-1]}};
        w_c = r_rm[WIDTH-1];
      end
      CL_RORW: begin
        w_y = r_rm;
        w_c = r_rm[WIDTH-1];
      end
      default: begin
        w_y = '0;
        w_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_c         <= 1'b0;
      r_tag_out   <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y       <= w_y;
        r_c       <= w_c;
        r_tag_out <= r_tag;
      end
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign carry_out = r_c;
  assign tag_out   = r_tag_out;

endmodule

// File: tb/tb_arm_shifter_pipe.sv
// Directed bench for arm_shifter_pipe: a 32-bit and a 16-bit instance sharing clock and reset.
module tb_arm_shifter_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        a_in_valid, a_in_ready, a_mode, a_cin, a_out_valid, a_out_ready, a_cout;
  logic [31:0] a_rm, a_y;
  logic [1:0]  a_type;
  logic [4:0]  a_imm;
  logic [7:0]  a_rs;
  logic [3:0]  a_tag_in, a_tag_out;

  logic        b_in_valid, b_in_ready, b_mode, b_cin, b_out_valid, b_out_ready, b_cout;
  logic [15:0] b_rm, b_y;
  logic [1:0]  b_type;
  logic [3:0]  b_imm;
  logic [7:0]  b_rs;
  logic [3:0]  b_tag_in, b_tag_out;

  arm_shifter_pipe #(.WIDTH(32), .AMT_W(8), .TAG_W(4)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rm(a_rm), .shift_type(a_type), .reg_mode(a_mode), .shift_imm(a_imm),
    .rs_amt(a_rs), .carry_in(a_cin), .tag_in(a_tag_in), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .y(a_y), .carry_out(a_cout), .tag_out(a_tag_out)
  );

  arm_shifter_pipe #(.WIDTH(16), .AMT_W(8), .TAG_W(4)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rm(b_rm), .shift_type(b_type), .reg_mode(b_mode), .shift_imm(b_imm),
    .rs_amt(b_rs), .carry_in(b_cin), .tag_in(b_tag_in), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .y(b_y), .carry_out(b_cout), .tag_out(b_tag_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op32(input string name, input logic [1:0] t, input logic m,
                      input logic [4:0] imm, input logic [7:0] rs, input logic [31:0] rm,
                      input logic cin, input logic [3:0] tg, input logic [31:0] ey,
                      input logic ec);
    @(negedge clk);
    a_type = t; a_mode = m; a_imm = imm; a_rs = rs; a_rm = rm; a_cin = cin;
    a_tag_in = tg; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    @(negedge clk);
    chk({name, ".early"}, a_out_valid, 0);
    @(negedge clk);
    chk({name, ".valid"}, a_out_valid, 1);
    chk({name, ".y"}, a_y, ey);
    chk({name, ".c"}, a_cout, ec);
    chk({name, ".tag"}, a_tag_out, tg);
  endtask

  task automatic op16(input string name, input logic [1:0] t, input logic m,
                      input logic [3:0] imm, input logic [7:0] rs, input logic [15:0] rm,
                      input logic cin, input logic [3:0] tg, input logic [15:0] ey,
                      input logic ec);
    @(negedge clk);
    b_type = t; b_mode = m; b_imm = imm; b_rs = rs; b_rm = rm; b_cin = cin;
    b_tag_in = tg; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({name, ".valid"}, b_out_valid, 1);
    chk({name, ".y"}, b_y, ey);
    chk({name, ".c"}, b_cout, ec);
    chk({name, ".tag"}, b_tag_out, tg);
  endtask

  initial begin
    int  sent;
    int  got;
    bit  stalled_prev;
    bit  saw_drop;

    reset = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_rm = '0; a_type = '0; a_mode = 1'b0;
    a_imm = '0; a_rs = '0; a_cin = 1'b0; a_tag_in = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_rm = '0; b_type = '0; b_mode = 1'b0;
    b_imm = '0; b_rs = '0; b_cin = 1'b0; b_tag_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.out_valid", a_out_valid, 0);
    chk("rst.y", a_y, 0);
    chk("rst.c", a_cout, 0);
    chk("rst.tag", a_tag_out, 0);
    chk("rst.in_ready", a_in_ready, 1);
    chk("rst16.out_valid", b_out_valid, 0);

    // Test 1
    op32("imm_lsl4", 2'b00, 1'b0, 5'd4, 8'd0, 32'h8000_000F, 1'b0, 4'h3, 32'h0000_00F0, 1'b0);
    // Test 2: #0 encodings
    op32("imm_lsr0", 2'b01, 1'b0, 5'd0, 8'd0, 32'h8000_0001, 1'b1, 4'h4, 32'h0, 1'b1);
    op32("imm_asr0", 2'b10, 1'b0, 5'd0, 8'd0, 32'h8000_0001, 1'b1, 4'h5, 32'hFFFF_FFFF, 1'b1);
    op32("imm_rrx", 2'b11, 1'b0, 5'd0, 8'd0, 32'h8000_0001, 1'b1, 4'h6, 32'hC000_0000, 1'b1);
    op32("imm_lsl0", 2'b00, 1'b0, 5'd0, 8'd0, 32'h8000_0001, 1'b1, 4'h7, 32'h8000_0001, 1'b1);
    // Test 3: register amounts at and past the width
    op32("reg_lsl32", 2'b00, 1'b1, 5'd0, 8'd32, 32'h1, 1'b0, 4'h8, 32'h0, 1'b1);
    op32("reg_lsl33", 2'b00, 1'b1, 5'd0, 8'd33, 32'h1, 1'b1, 4'h9, 32'h0, 1'b0);
    op32("reg_ror64", 2'b11, 1'b1, 5'd0, 8'd64, 32'h1, 1'b1, 4'hA, 32'h1, 1'b0);
    op32("reg_ror0", 2'b11, 1'b1, 5'd0, 8'd0, 32'h1, 1'b1, 4'hB, 32'h1, 1'b1);
    op32("reg_lsr32", 2'b01, 1'b1, 5'd0, 8'd32, 32'h8000_0000, 1'b0, 4'hC, 32'h0, 1'b1);
    op32("reg_asr4", 2'b10, 1'b1, 5'd0, 8'd4, 32'h8000_0018, 1'b0, 4'hD, 32'hF800_0001, 1'b1);
    op32("reg_ror8", 2'b11, 1'b1, 5'd0, 8'd8, 32'h1234_5680, 1'b0, 4'hE, 32'h8012_3456, 1'b1);
    op32("reg_lsr40", 2'b01, 1'b1, 5'd0, 8'd40, 32'hFFFF_FFFF, 1'b1, 4'h1, 32'h0, 1'b0);

    // Test 4: six ops, out_ready low for cycles 3..7; op k is LSL #k of 1 with tag k
    sent = 0; got = 0; stalled_prev = 1'b0; saw_drop = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      a_out_ready = !(cyc >= 3 && cyc <= 7);
      if (sent < 6) begin
        a_in_valid = 1'b1; a_mode = 1'b0; a_type = 2'b00; a_imm = 5'(sent + 1);
        a_rm = 32'h1; a_cin = 1'b0; a_tag_in = 4'(sent + 1);
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (stalled_prev) chk("bp.hold_valid", a_out_valid, 1);
      if (!a_in_ready && !saw_drop) begin
        saw_drop = 1'b1;
        chk("bp.buffered", 64'(sent - got), 2);
      end
      if (a_out_valid) begin
        chk("bp.tag", a_tag_out, 64'(got + 1));
        chk("bp.y", a_y, 64'(32'h1 << (got + 1)));
        chk("bp.c", a_cout, 0);
        if (a_out_ready) got++;
      end
      stalled_prev = a_out_valid && !a_out_ready;
      if (a_in_valid && a_in_ready) sent++;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    chk("bp.received", 64'(got), 6);
    chk("bp.sent", 64'(sent), 6);
    chk("bp.saw_drop", 64'(saw_drop), 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp.no_dup", a_out_valid, 0);
    end

    // Test 5: reset with two ops in flight
    @(negedge clk);
    a_in_valid = 1'b1; a_mode = 1'b0; a_type = 2'b01; a_imm = 5'd1; a_rm = 32'h3;
    a_cin = 1'b0; a_tag_in = 4'h9; a_out_ready = 1'b1;
    @(negedge clk);
    a_tag_in = 4'hA;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("rst2.pre_tag", a_tag_out, 4'h9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2.out_valid", a_out_valid, 0);
    chk("rst2.y", a_y, 0);
    chk("rst2.c", a_cout, 0);
    chk("rst2.in_ready", a_in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("rst2.discarded", a_out_valid, 0);
    end

    // Test 6: 16-bit instance
    op16("w16_asr200", 2'b10, 1'b1, 4'd0, 8'd200, 16'h8001, 1'b0, 4'h2, 16'hFFFF, 1'b1);
    op16("w16_ror3", 2'b11, 1'b0, 4'd3, 8'd0, 16'h0005, 1'b0, 4'h6, 16'hA000, 1'b1);
    op16("w16_lsl16", 2'b00, 1'b1, 4'd0, 8'd16, 16'h0001, 1'b0, 4'h7, 16'h0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arm_shifter_pipe.md
Name: arm_shifter_pipe

Overview:
Parametrised, pipelined ARM data-processing shifter operand unit. Supports immediate-specified shifts (LSL/LSR/ASR/ROR/RRX with the #0 encodings) and register-specified shifts (amount from Rs[7:0], including amounts >= WIDTH). Uses a valid/ready handshake on both sides. Sits between the register-file read stage and the ALU.

Parameters:
WIDTH, 32, operand width; power of two, 8..64
SH_W, $clog2(WIDTH), immediate shift field width (derived; do not override)
AMT_W, 8, register shift amount width (Rs low byte)
TAG_W, 4, sideband tag carried with each operation

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  input operation valid
in_ready  out  1  unit can accept an operation this cycle
rm  in  WIDTH  operand to shift
shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
reg_mode  in  1  0 = immediate amount (shift_imm); 1 = register amount (rs_amt)
shift_imm  in  SH_W  immediate shift amount
rs_amt  in  AMT_W  register shift amount
carry_in  in  1  current C flag
tag_in  in  TAG_W  sideband tag, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y  out  WIDTH  shifted operand
carry_out  out  1  shifter carry-out
tag_out  out  TAG_W  tag of the current result

Behaviour:
- Two registered stages.
  - S1 captures rm, carry_in, tag, and the decoded effective amount/class.
  - S2 holds y, carry_out, tag_out.
  - Latency: 2 cycles from accept to out_valid when out_ready stays high.
  - Throughput: 1 operation per cycle.
- Handshake:
  - An input is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational, no dependence on in_valid).
  - While stalled, all stage registers hold. y, carry_out and tag_out stay stable while out_valid && !out_ready.
  - No operation is dropped or duplicated.
- Reset:
  - out_valid = 0, S1 valid = 0, y = 0, carry_out = 0, tag_out = 0; in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight operations.
- Immediate mode, n = shift_imm:
  - n = 0:
    - LSL: y = rm, C = carry_in.
    - LSR: treated as LSR #WIDTH, so y = 0, C = rm[W-1].
    - ASR: treated as ASR #WIDTH, so y = all rm[W-1], C = rm[W-1].
    - ROR: RRX, so y = {carry_in, rm[W-1:1]}, C = rm[0].
  - n != 0: as the register mode rows for 1..W-1.
- Register mode, n = rs_amt (full AMT_W bits):
  - n = 0: all types give y = rm, C = carry_in.
  - LSL:
    - 1..W-1: y = rm << n, C = rm[W-n].
    - n = W: y = 0, C = rm[0].
    - n > W: y = 0, C = 0.
  - LSR:
    - 1..W-1: y = rm >> n, C = rm[n-1].
    - n = W: y = 0, C = rm[W-1].
    - n > W: y = 0, C = 0.
  - ASR:
    - 1..W-1: arithmetic shift, C = rm[n-1].
    - n >= W: y = all rm[W-1], C = rm[W-1].
  - ROR: let r = n mod W.
    - r = 0 (n != 0): y = rm, C = rm[W-1].
    - otherwise: y = rm rotated right by r, C = rm[r-1].
- Carry index arithmetic uses SH_W+1 bits; no out-of-range bit selects. All outputs are fully defined (no X/Z) for every input combination.

Test Plan:
1. Immediate LSL #4, rm=32'h8000_000F, carry_in=0 -> y=32'h0000_00F0, carry_out=0, 2 cycles after accept, tag_out=tag_in.
2. Immediate #0 encodings, rm=32'h8000_0001, carry_in=1:
   - LSR -> y=0, C=1.
   - ASR -> y=32'hFFFF_FFFF, C=1.
   - ROR (RRX) -> y=32'hC000_0000, C=1.
   - LSL -> y=rm, C=1.
3. Register mode, rm=32'h0000_0001:
   - LSL rs=32 -> y=0, C=1.
   - LSL rs=33 -> y=0, C=0.
   - ROR rs=64 -> y=rm, C=0.
   - ROR rs=0 with carry_in=1 -> y=rm, C=1.
4. Backpressure: stream 6 tagged ops with out_ready low for cycles 3-7.
   - in_ready drops after 2 ops are buffered.
   - Outputs hold stable while stalled.
   - All 6 results emerge in order with correct tags, none lost or duplicated.
5. Reset asserted with 2 ops in flight -> next cycle out_valid=0, y=0, carry_out=0, in_ready=1; the discarded ops never appear.
6. WIDTH=16 instance, register ASR rs=200, rm=16'h8001 -> y=16'hFFFF, C=1; immediate ROR #3, rm=16'h0005 -> y=16'hA000, C=1.
